hazard_ctrl: RTL and testbench

Parametrised hazard, forwarding and stall controller for the 5-stage pipelined core, replacing the separate hazard-detection and forwarding units. It keeps a shadow copy of the destination and control state of the ID/EX, EX/MEM and MEM/WB stages, and advances that copy using its own stall decisions. From this state it drives:
- PC and pipeline-register enables;
- bubbles and flushes;
- EX operand forwarding selects.

---
 rtl/hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard, forwarding and stall controller for a 5-stage core.
//                Tracks shadow EX/MEM/WB state to drive enables, bubbles and
//                EX operand forwarding selects; supports a multi-cycle EX op.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int RA_W   = 5,
    parameter int MC_LAT = 4,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid_i,
    input  logic [RA_W-1:0] id_rs1_i,
    input  logic [RA_W-1:0] id_rs2_i,
    input  logic            id_use1_i,
    input  logic            id_use2_i,
    input  logic [RA_W-1:0] id_rd_i,
    input  logic            id_regwrite_i,
    input  logic            id_memread_i,
    input  logic            id_branch_i,
    input  logic            id_mc_i,
    input  logic            branch_taken_i,
    output logic            pc_write_o,
    output logic            if_id_write_o,
    output logic            id_ex_write_o,
    output logic            if_id_flush_o,
    output logic            id_ex_bubble_o,
    output logic            ex_mem_bubble_o,
    output logic [1:0]      forward_a_o,
    output logic [1:0]      forward_b_o,
    output logic            mc_start_o,
    output logic            mc_busy_o
);

    localparam int              CNT_W    = $clog2(MC_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 1);

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic            use1;
        logic            use2;
        logic            regwrite;
        logic            memread;
        logic            mc;
        logic            first;
    } ex_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic            memread;
    } mem_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            regwrite;
    } wb_t;

    ex_t             ex_q, ex_d;
    mem_t            mem_q, mem_d;
    wb_t             wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic w_mc_hold;
    logic w_ex_wr, w_mem_wr, w_wb_wr;
    logic w_dep_ex, w_dep_mem;
    logic w_load_use, w_raw_nofwd, w_br_dep, w_stall;

    assign w_mc_hold = (cnt_q != '0);
    assign w_ex_wr   = ex_q.valid  & ex_q.regwrite  & (ex_q.rd  != '0);
    assign w_mem_wr  = mem_q.valid & mem_q.regwrite & (mem_q.rd != '0);
    assign w_wb_wr   = wb_q.valid  & wb_q.regwrite  & (wb_q.rd  != '0);

    assign w_dep_ex  = w_ex_wr & id_valid_i &
                       ((id_use1_i & (id_rs1_i == ex_q.rd)) | (id_use2_i & (id_rs2_i == ex_q.rd)));
    assign w_dep_mem = w_mem_wr & id_valid_i &
                       ((id_use1_i & (id_rs1_i == mem_q.rd)) | (id_use2_i & (id_rs2_i == mem_q.rd)));

    // The ID comparator cannot take forwarded EX results, nor a load still in MEM.
    assign w_br_dep  = id_valid_i & id_branch_i & (w_dep_ex | (w_dep_mem & mem_q.memread));

    generate
        if (FWD_EN) begin : g_fwd
            assign w_load_use  = w_dep_ex & ex_q.memread;
            assign w_raw_nofwd = 1'b0;
            assign forward_a_o = (w_mem_wr && ex_q.use1 && (mem_q.rd == ex_q.rs1)) ? 2'b10 :
                                 (w_wb_wr  && ex_q.use1 && (wb_q.rd  == ex_q.rs1)) ? 2'b01 : 2'b00;
            assign forward_b_o = (w_mem_wr && ex_q.use2 && (mem_q.rd == ex_q.rs2)) ? 2'b10 :
                                 (w_wb_wr  && ex_q.use2 && (wb_q.rd  == ex_q.rs2)) ? 2'b01 : 2'b00;
        end else begin : g_nofwd
            logic w_dep_wb;
            logic w_unused_ok;
            assign w_dep_wb    = w_wb_wr & id_valid_i &
                                 ((id_use1_i & (id_rs1_i == wb_q.rd)) | (id_use2_i & (id_rs2_i == wb_q.rd)));
            assign w_load_use  = 1'b0;
            assign w_raw_nofwd = w_dep_ex | w_dep_mem | w_dep_wb;
            assign forward_a_o = 2'b00;
            assign forward_b_o = 2'b00;
            assign w_unused_ok = ^{ex_q.rs1, ex_q.rs2, ex_q.use1, ex_q.use2};
        end
    endgenerate

    assign w_stall = ~w_mc_hold & (w_load_use | w_raw_nofwd | w_br_dep);

    always_comb begin
        pc_write_o      = 1'b1;
        if_id_write_o   = 1'b1;
        id_ex_write_o   = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        ex_mem_bubble_o = 1'b0;
        if (w_mc_hold) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            id_ex_write_o   = 1'b0;
            ex_mem_bubble_o = 1'b1;
        end else if (w_stall) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
        end
    end

    assign mc_start_o = ex_q.valid & ex_q.mc & ex_q.first;
    // Busy spans the whole EX residency, including the final non-holding cycle.
    assign mc_busy_o  = ex_q.valid & ex_q.mc;

    always_comb begin
        wb_d.valid    = mem_q.valid;
        wb_d.rd       = mem_q.rd;
        wb_d.regwrite = mem_q.regwrite;

        mem_d = '0;
        if (!w_mc_hold) begin
            mem_d.valid    = ex_q.valid;
            mem_d.rd       = ex_q.rd;
            mem_d.regwrite = ex_q.regwrite;
            mem_d.memread  = ex_q.memread;
        end

        ex_d       = ex_q;
        ex_d.first = 1'b0;
        cnt_d      = cnt_q;
        if (w_mc_hold) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (w_stall || !id_valid_i) begin
            ex_d = '0;
        end else begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = id_rd_i;
            ex_d.rs1      = id_rs1_i;
            ex_d.rs2      = id_rs2_i;
            ex_d.use1     = id_use1_i;
            ex_d.use2     = id_use2_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
            ex_d.mc       = id_mc_i;
            ex_d.first    = 1'b1;
            if (id_mc_i) begin
                cnt_d = CNT_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl (forwarding and
//                no-forwarding instances) with a pipeline-occupancy model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int RA_W   = 5;
    localparam int MC_LAT = 4;

    typedef struct packed {
        logic       v;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, rw, mr, mc, br;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ins_t cur;
    logic taken;

    logic [1:0] pcw, ifw, idw, fl, idb, exb, mcs, mcb;
    logic [1:0] fa [2];
    logic [1:0] fb [2];

    int errors = 0;
    int checks = 0;

    // Model: instruction occupying each stage plus cycles spent in EX so far.
    ins_t m_ex [2];
    ins_t m_mem[2];
    ins_t m_wb [2];
    int   m_age[2];

    always #5 clk = ~clk;

    hazard_ctrl #(.RA_W(RA_W), .MC_LAT(MC_LAT), .FWD_EN(1'b1)) u_fwd (
        .clk(clk), .rst(rst),
        .id_valid_i(cur.v), .id_rs1_i(cur.rs1), .id_rs2_i(cur.rs2),
        .id_use1_i(cur.u1), .id_use2_i(cur.u2), .id_rd_i(cur.rd),
        .id_regwrite_i(cur.rw), .id_memread_i(cur.mr), .id_branch_i(cur.br),
        .id_mc_i(cur.mc), .branch_taken_i(taken),
        .pc_write_o(pcw[0]), .if_id_write_o(ifw[0]), .id_ex_write_o(idw[0]),
        .if_id_flush_o(fl[0]), .id_ex_bubble_o(idb[0]), .ex_mem_bubble_o(exb[0]),
        .forward_a_o(fa[0]), .forward_b_o(fb[0]),
        .mc_start_o(mcs[0]), .mc_busy_o(mcb[0])
    );

    hazard_ctrl #(.RA_W(RA_W), .MC_LAT(MC_LAT), .FWD_EN(1'b0)) u_nf (
        .clk(clk), .rst(rst),
        .id_valid_i(cur.v), .id_rs1_i(cur.rs1), .id_rs2_i(cur.rs2),
        .id_use1_i(cur.u1), .id_use2_i(cur.u2), .id_rd_i(cur.rd),
        .id_regwrite_i(cur.rw), .id_memread_i(cur.mr), .id_branch_i(cur.br),
        .id_mc_i(cur.mc), .branch_taken_i(taken),
        .pc_write_o(pcw[1]), .if_id_write_o(ifw[1]), .id_ex_write_o(idw[1]),
        .if_id_flush_o(fl[1]), .id_ex_bubble_o(idb[1]), .ex_mem_bubble_o(exb[1]),
        .forward_a_o(fa[1]), .forward_b_o(fb[1]),
        .mc_start_o(mcs[1]), .mc_busy_o(mcb[1])
    );

    function automatic logic [11:0] obs(input int k);
        return {pcw[k], ifw[k], idw[k], fl[k], idb[k], exb[k], fa[k], fb[k], mcs[k], mcb[k]};
    endfunction

    task automatic drive(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                         input int d, input bit w, input bit m, input bit b, input bit c,
                         input bit t);
        cur.v  = v;   cur.rs1 = 5'(r1); cur.u1 = u1; cur.rs2 = 5'(r2); cur.u2 = u2;
        cur.rd = 5'(d); cur.rw = w; cur.mr = m; cur.br = b; cur.mc = c;
        taken  = t;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nop();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic bit writer(input ins_t s);
        return s.v && s.rw && (s.rd != 5'd0);
    endfunction

    function automatic bit reads(input ins_t id, input logic [4:0] r);
        return id.v && ((id.u1 && id.rs1 == r) || (id.u2 && id.rs2 == r));
    endfunction

    function automatic bit m_hold(input int k);
        return m_ex[k].v && m_ex[k].mc && (m_age[k] < MC_LAT);
    endfunction

    function automatic bit m_stall(input int k, input bit fwd);
        bit de, dm, dw;
        de = writer(m_ex[k])  && reads(cur, m_ex[k].rd);
        dm = writer(m_mem[k]) && reads(cur, m_mem[k].rd);
        dw = writer(m_wb[k])  && reads(cur, m_wb[k].rd);
        if (m_hold(k)) return 1'b0;
        if (fwd && de && m_ex[k].mr) return 1'b1;
        if (!fwd && (de || dm || dw)) return 1'b1;
        return cur.v && cur.br && (de || (dm && m_mem[k].mr));
    endfunction

    function automatic logic [1:0] m_sel(input int k, input bit fwd, input logic [4:0] src,
                                         input logic u);
        if (!fwd || !u) return 2'b00;
        if (writer(m_mem[k]) && m_mem[k].rd == src) return 2'b10;
        if (writer(m_wb[k])  && m_wb[k].rd  == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [11:0] m_expect(input int k, input bit fwd);
        bit h, s, go;
        h  = m_hold(k);
        s  = m_stall(k, fwd);
        go = !h && !s;
        return {go, go, !h, go && taken, s, h,
                m_sel(k, fwd, m_ex[k].rs1, m_ex[k].u1), m_sel(k, fwd, m_ex[k].rs2, m_ex[k].u2),
                m_ex[k].v && m_ex[k].mc && (m_age[k] == 1), m_ex[k].v && m_ex[k].mc};
    endfunction

    task automatic m_step(input int k, input bit fwd);
        bit h, s;
        h = m_hold(k);
        s = m_stall(k, fwd);
        m_wb[k] = m_mem[k];
        if (h) begin
            m_mem[k] = '0;
            m_age[k]++;
        end else begin
            m_mem[k] = m_ex[k];
            m_ex[k]  = (s || !cur.v) ? '0 : cur;
            m_age[k] = 1;
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_age[k] = 1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== 12'b1110_0000_0000) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %b want 111000000000", k, obs(k));
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);             // lw x5
        @(negedge clk);
        checks++;
        if ({pcw[0], idb[0]} !== 2'b10) begin
            errors++; $display("FAIL lu_first got pc/bub=%b want 10", {pcw[0], idb[0]});
        end
        step();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0);             // add x6,x5,x1
        @(negedge clk);
        checks++;
        if ({pcw[0], ifw[0], idb[0]} !== 3'b001) begin
            errors++; $display("FAIL lu_stall got %b want 001", {pcw[0], ifw[0], idb[0]});
        end
        step();
        @(negedge clk);
        checks++;
        if ({pcw[0], ifw[0], idb[0]} !== 3'b110) begin
            errors++; $display("FAIL lu_release got %b want 110", {pcw[0], ifw[0], idb[0]});
        end
        step();
        nop();
        @(negedge clk);
        checks++;
        if ({fa[0], fb[0]} !== 4'b0100) begin
            errors++; $display("FAIL lu_forward got a/b=%b want 0100", {fa[0], fb[0]});
        end
    endtask

    task automatic test_alu_chain();
        do_reset();
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);             // add x3,x1,x2
        step();
        drive(1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 0);             // sub x4,x3,x3
        @(negedge clk);
        checks++;
        if ({pcw[0], idb[0]} !== 2'b10) begin
            errors++; $display("FAIL alu_nostall got %b want 10", {pcw[0], idb[0]});
        end
        step();
        drive(1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0);             // add x0,x1,x2
        @(negedge clk);
        checks++;
        if ({fa[0], fb[0]} !== 4'b1010) begin
            errors++; $display("FAIL alu_forward got a/b=%b want 1010", {fa[0], fb[0]});
        end
        step();
        drive(1, 0, 1, 0, 1, 4, 1, 0, 0, 0, 0);             // sub x4,x0,x0
        @(negedge clk);
        checks++;
        if ({pcw[0], idb[0]} !== 2'b10) begin
            errors++; $display("FAIL x0_nostall got %b want 10", {pcw[0], idb[0]});
        end
        step();
        nop();
        @(negedge clk);
        checks++;
        if ({fa[0], fb[0]} !== 4'b0000) begin
            errors++; $display("FAIL x0_noforward got a/b=%b want 0000", {fa[0], fb[0]});
        end
    endtask

    task automatic test_branch_after_load();
        logic [1:0] want [3];
        want[0] = 2'b00; want[1] = 2'b00; want[2] = 2'b11;
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);             // lw x7
        step();
        drive(1, 7, 1, 0, 1, 0, 0, 0, 1, 0, 1);             // beq x7,x0 (taken)
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({pcw[0], fl[0]} !== want[c]) begin
                errors++;
                $display("FAIL br_load cycle %0d got pc/flush=%b want %b", c, {pcw[0], fl[0]}, want[c]);
            end
            step();
        end
        nop();
        @(negedge clk);
        checks++;
        if (fl[0] !== 1'b0) begin
            errors++; $display("FAIL br_flush_once got %b want 0", fl[0]);
        end
    endtask

    task automatic test_multicycle();
        int n_start, n_busy, n_hold;
        n_start = 0; n_busy = 0; n_hold = 0;
        do_reset();
        drive(1, 1, 1, 2, 1, 9, 1, 0, 0, 1, 0);             // mul x9 (multi-cycle)
        step();
        drive(1, 9, 1, 0, 1, 10, 1, 0, 0, 0, 0);            // add x10,x9,x0
        for (int c = 0; c < MC_LAT; c++) begin
            @(negedge clk);
            n_start += int'(mcs[0]);
            n_busy  += int'(mcb[0]);
            if (pcw[0] === 1'b0 && exb[0] === 1'b1) n_hold++;
            step();
        end
        nop();
        @(negedge clk);
        checks++;
        if (n_start !== 1) begin errors++; $display("FAIL mc_start_cycles got %0d want 1", n_start); end
        checks++;
        if (n_busy !== 4) begin errors++; $display("FAIL mc_busy_cycles got %0d want 4", n_busy); end
        checks++;
        if (n_hold !== 3) begin errors++; $display("FAIL mc_hold_cycles got %0d want 3", n_hold); end
        checks++;
        if ({fa[0], mcb[0]} !== 3'b100) begin
            errors++; $display("FAIL mc_forward got fa/busy=%b want 100", {fa[0], mcb[0]});
        end
    endtask

    task automatic test_nofwd();
        int n_stall, n_fwd;
        n_stall = 0; n_fwd = 0;
        do_reset();
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);             // add x3
        step();
        drive(1, 3, 1, 0, 1, 4, 1, 0, 0, 0, 0);             // or x4,x3,x0
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (pcw[1] === 1'b0) n_stall++;
            if ({fa[1], fb[1]} !== 4'b0000) n_fwd++;
            step();
        end
        nop();
        @(negedge clk);
        if ({fa[1], fb[1]} !== 4'b0000) n_fwd++;
        checks++;
        if (n_stall !== 3) begin errors++; $display("FAIL nofwd_stalls got %0d want 3", n_stall); end
        checks++;
        if (n_fwd !== 0) begin errors++; $display("FAIL nofwd_selects got %0d nonzero want 0", n_fwd); end
    endtask

    task automatic test_reset_midhold();
        do_reset();
        drive(1, 1, 1, 2, 1, 9, 1, 0, 0, 1, 0);
        step();
        drive(1, 9, 1, 0, 1, 10, 1, 0, 0, 0, 0);
        step();                                             // now in hold cycle 2
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mcb[0], pcw[0], fa[0], fb[0]} !== 6'b010000) begin
            errors++;
            $display("FAIL reset_midhold got busy/pc/fa/fb=%b want 010000", {mcb[0], pcw[0], fa[0], fb[0]});
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [11:0] exp;
        do_reset();
        m_reset();
        for (int n = 0; n < 600; n++) begin
            cur.v   = ($urandom_range(0, 7) != 0);
            cur.rd  = 5'($urandom_range(0, 3));
            cur.rs1 = 5'($urandom_range(0, 3));
            cur.rs2 = 5'($urandom_range(0, 3));
            cur.u1  = 1'($urandom_range(0, 1));
            cur.u2  = 1'($urandom_range(0, 1));
            cur.rw  = ($urandom_range(0, 3) != 0);
            cur.mr  = cur.rw && ($urandom_range(0, 3) == 0);
            cur.mc  = !cur.mr && ($urandom_range(0, 5) == 0);
            cur.br  = !cur.mc && ($urandom_range(0, 4) == 0);
            taken   = cur.v && cur.br && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                exp = m_expect(k, k == 0);
                checks++;
                if (obs(k) !== exp) begin
                    errors++;
                    $display("FAIL random dut%0d cycle %0d got %b want %b", k, n, obs(k), exp);
                end
            end
            m_step(0, 1'b1);
            m_step(1, 1'b0);
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        nop();
        test_reset();
        test_load_use();
        test_alu_chain();
        test_branch_after_load();
        test_multicycle();
        test_nofwd();
        test_reset_midhold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
